// File: rtl/bit_filling.sv
// Builds a run of WIDTH-bit ones one bit per clock, from LSB or MSB.
// Ports: clk, reset (async active-low), start/count/align in; pattern/done/err out.
module bit_filling #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       count,
  input  logic             align,
  output logic [WIDTH-1:0] pattern,
  output logic             done,
  output logic             err
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam logic [4:0] WMAX = 5'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   remaining;
  logic            dir;
  logic            over;
  logic [RW-1:0]   load;
  logic [WIDTH-1:0] fill_lsb;
  logic [WIDTH-1:0] fill_msb;

  assign over     = {1'b0, count} > WMAX;
  assign load     = over ? RW'(WIDTH) : RW'(count);
  assign fill_lsb = {pattern[WIDTH-2:0], 1'b1};
  assign fill_msb = {1'b1, pattern[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      dir       <= 1'b0;
      pattern   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pattern <= '0;
          done    <= 1'b0;
          if (start) begin
            state     <= BUILD;
            remaining <= load;
            dir       <= align;
            err       <= over;
          end else begin
            err <= 1'b0;
          end
        end
        BUILD: begin
          if (remaining != '0) begin
            pattern   <= dir ? fill_msb : fill_lsb;
            remaining <= remaining - RW'(1);
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            state   <= IDLE;
            pattern <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          pattern   <= '0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_filling.sv
// Directed vector bench for bit_filling at WIDTH = 8.
// Table-driven builds plus hold, early-drop and mid-build reset sequences.
module tb_bit_filling;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic       align;
  logic [7:0] pattern;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  bit_filling #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .count  (count),
    .align  (align),
    .pattern(pattern),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       al;
    logic [7:0] pat;
    logic       er;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    count = v.cnt;
    align = v.al;
    start = 1'b1;
    tick();
    chk({tag, "_err_early"}, err, v.er);
    chk({tag, "_pat_early"}, pattern, 0);
    wait_done(lat);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_pat"}, pattern, v.pat);
    chk({tag, "_err"}, err, v.er);
    start = 1'b0;
    count = 4'd0;
    tick();
    chk({tag, "_idle"}, {pattern, done, err}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [9:0] snap;
    vecs[0] = '{4'd3,  1'b0, 8'h07, 1'b0, 4};
    vecs[1] = '{4'd5,  1'b1, 8'hF8, 1'b0, 6};
    vecs[2] = '{4'd0,  1'b0, 8'h00, 1'b0, 1};
    vecs[3] = '{4'd8,  1'b0, 8'hFF, 1'b0, 9};
    vecs[4] = '{4'd12, 1'b0, 8'hFF, 1'b1, 9};
    vecs[5] = '{4'd12, 1'b1, 8'hFF, 1'b1, 9};
    vecs[6] = '{4'd1,  1'b1, 8'h80, 1'b0, 2};
    vecs[7] = '{4'd7,  1'b1, 8'hFE, 1'b0, 8};
    vecs[8] = '{4'd15, 1'b1, 8'hFF, 1'b1, 9};
    vecs[9] = '{4'd9,  1'b0, 8'hFF, 1'b1, 9};

    start = 1'b0;
    count = 4'd0;
    align = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async", {pattern, done, err}, 0);
    #20;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_hold", {pattern, done, err}, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // DONE hold with count/align wiggling
    @(negedge clk);
    count = 4'd4;
    align = 1'b1;
    start = 1'b1;
    tick();
    wait_done(lat);
    chk("hold_lat", lat, 5);
    chk("hold_pat", pattern, 8'hF0);
    snap = {pattern, done, err};
    for (int k = 0; k < 3; k++) begin
      count = 4'(k + 9);
      align = k[0];
      tick();
      chk($sformatf("hold_stable%0d", k), {pattern, done, err}, snap);
    end
    start = 1'b0;
    tick();
    chk("hold_release", {pattern, done, err}, 0);

    // start dropped during BUILD: build still completes
    @(negedge clk);
    count = 4'd6;
    align = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("drop_lat", lat, 7);
    chk("drop_pat", pattern, 8'h3F);
    tick();
    chk("drop_idle", {pattern, done, err}, 0);

    // reset mid-BUILD, between edges
    @(negedge clk);
    count = 4'd6;
    align = 1'b0;
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid_pat", pattern, 8'h03);
    #2;
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_mid_clear", {pattern, done, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst_no_resume", {pattern, done, err}, 0);
    run_vec('{4'd2, 1'b0, 8'h03, 1'b0, 3}, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_filling.md
BIT_FILLING -- requirements
Module: bit_filling

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the pattern width in bits; the legal range is 2..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 forces the reset state immediately, with no clock needed.
REQ-004 SHALL have port start, input, 1 bit: request to build a pattern; must be held high until done is seen.
REQ-005 SHALL have port count, input, 4 bits: the number of 1 bits to place; sampled only in IDLE.
REQ-006 SHALL have port align, input, 1 bit: 0 = fill from the LSB upward, 1 = fill from the MSB downward; sampled only in IDLE.
REQ-007 SHALL have port pattern, output, WIDTH bits: the pattern under construction or the final pattern.
REQ-008 SHALL have port done, output, 1 bit: high while the final pattern is valid.
REQ-009 SHALL have port err, output, 1 bit: high when the requested count exceeded WIDTH and was clamped.

Function
REQ-010 SHALL implement a registered state machine with three states: IDLE, BUILD and DONE.
REQ-011 SHALL, in IDLE with start = 0, stay in IDLE and hold pattern = 0, done = 0 and err = 0.
REQ-012 SHALL, on the edge where start = 1 in IDLE:
- move to BUILD;
- load the internal remaining counter with min(count, WIDTH);
- latch align;
- set err to (count > WIDTH);
- clear pattern to 0.
REQ-013 SHALL, on each edge in BUILD with remaining != 0:
- if align = 0, shift pattern left one bit, inserting 1 at bit 0;
- if align = 1, shift pattern right one bit, inserting 1 at bit WIDTH-1;
- decrement remaining by 1.
REQ-014 SHALL, on the edge in BUILD with remaining = 0, set done to 1 and move to DONE; pattern is unchanged on that edge.
REQ-015 SHALL give done-latency exactly N+1 rising edges after the start-sampling edge, where N = min(count, WIDTH).
REQ-016 SHALL, in DONE, hold pattern, done and err for as long as start = 1.
REQ-017 SHALL, on the edge where start = 0 in DONE, move to IDLE and clear pattern, done and err.
REQ-018 SHALL ignore changes on count and align while in BUILD or DONE.
REQ-019 SHALL ignore start dropping to 0 during BUILD; the build runs to completion, then REQ-017 applies on the first edge in DONE.
REQ-020 SHALL make the remaining counter wide enough to hold WIDTH without wrap-around, and it shall never decrement below 0.
REQ-021 SHALL treat count = 0 as legal: pattern = 0 and done is asserted after exactly 1 edge.
REQ-022 SHALL treat count = WIDTH as legal: pattern is all ones and err = 0.
REQ-023 SHALL drive every output from registers, with no combinational path from any input to any output.

Reset
REQ-024 SHALL, whenever reset = 0, immediately force the state to IDLE and set pattern = 0, done = 0, err = 0 and remaining = 0, regardless of clk.
REQ-025 SHALL, when reset is asserted mid-BUILD or in DONE, abandon the operation; after reset is released, a new start is required.
REQ-026 SHALL resume sampling on the first rising clk edge after reset returns to 1.

Verification (WIDTH = 8)
REQ-027 SHALL cover: count = 3, align = 0, start held -> done = 1 after edge 4, pattern = 8'b0000_0111, err = 0.
REQ-028 SHALL cover: count = 5, align = 1 -> done after edge 6, pattern = 8'b1111_1000.
REQ-029 SHALL cover: count = 0 -> done after edge 1, pattern = 8'h00; then count = 8 -> pattern = 8'hFF, err = 0, done after edge 9.
REQ-030 SHALL cover: count = 12 -> err = 1 from edge 1, pattern = 8'hFF, done after edge 9.
REQ-031 SHALL cover: in DONE, hold start = 1 for 3 cycles while changing count and align -> outputs stable; drop start -> next edge gives IDLE with all outputs 0.
REQ-032 SHALL cover: reset = 0 applied between edges mid-BUILD (count = 6) -> pattern, done and err go to 0 before the next edge; after release, a fresh start with count = 2 yields 8'b0000_0011.
